// File: rtl/uart_display_buffer_if.sv
// Display buffer bus: received UART bytes in, scanned 7-segment digit data out.
// The UART side strobes rx_valid; the display side reads ascii_out/digit_sel/scan_idx.
// char_count reports how many digit positions currently hold a character.
interface uart_display_buffer_if #(
  parameter int NUM_DIGITS = 4
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [7:0]            ascii_out;
  logic [NUM_DIGITS-1:0] digit_sel;
  logic [3:0]            char_count;
  logic [2:0]            scan_idx;

  modport master (
    output rx_data, rx_valid,
    input  ascii_out, digit_sel, char_count, scan_idx
  );

  modport slave (
    input  rx_data, rx_valid,
    output ascii_out, digit_sel, char_count, scan_idx
  );
endinterface

// File: rtl/uart_display_buffer.sv
// Shift-in character buffer for a multiplexed 7-segment display, with backspace/ESC editing.
// Latency: a received byte is visible on the outputs one clock after its rx_valid cycle.
// Backpressure: none; bytes are accepted every cycle and a full buffer drops its oldest char.
module uart_display_buffer #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input logic                  clk,
  input logic                  reset,
  uart_display_buffer_if.slave bus
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] ESC   = 8'h1B;

  logic [7:0]            chars_q [NUM_DIGITS];
  logic [7:0]            chars_d [NUM_DIGITS];
  logic [3:0]            count_q;
  logic [3:0]            count_d;
  logic [PW-1:0]         presc_q;
  logic [IW-1:0]         scan_q;
  logic                  tick;
  logic [NUM_DIGITS-1:0] sel;

  assign tick = (presc_q == PW'(SCAN_DIV - 1));

  // Prescaler: free-running 0..SCAN_DIV-1, independent of rx traffic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + 1'b1;
  end

  // Scan position: advance one digit per tick, wrapping at the last digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              scan_q <= '0;
    else if (tick) begin
      if (scan_q == IW'(NUM_DIGITS - 1))    scan_q <= '0;
      else                                  scan_q <= scan_q + 1'b1;
    end
  end

  // Buffer editing: printable shifts in at digit 0, backspace shifts out, ESC clears.
  always_comb begin
    chars_d = chars_q;
    count_d = count_q;
    if (bus.rx_valid) begin
      if (bus.rx_data >= 8'h20 && bus.rx_data <= 8'h7E) begin
        for (int i = NUM_DIGITS - 1; i > 0; i--) chars_d[i] = chars_q[i-1];
        chars_d[0] = bus.rx_data;
        if (count_q != 4'(NUM_DIGITS)) count_d = count_q + 4'd1;
      end else if (bus.rx_data == BS) begin
        if (count_q != 4'd0) begin
          for (int i = 0; i < NUM_DIGITS - 1; i++) chars_d[i] = chars_q[i+1];
          chars_d[NUM_DIGITS-1] = SPACE;
          count_d = count_q - 4'd1;
        end
      end else if (bus.rx_data == ESC) begin
        for (int i = 0; i < NUM_DIGITS; i++) chars_d[i] = SPACE;
        count_d = 4'd0;
      end
    end
  end

  // Buffer and occupancy registers; reset fills with blanks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) chars_q[i] <= SPACE;
      count_q <= 4'd0;
    end else begin
      chars_q <= chars_d;
      count_q <= count_d;
    end
  end

  // Digit enable: light the scanned digit only if it holds a character.
  always_comb begin
    sel = '1;
    if (4'(scan_q) < count_q) sel[scan_q] = 1'b0;
  end

  assign bus.ascii_out  = chars_q[scan_q];
  assign bus.digit_sel  = sel;
  assign bus.char_count = count_q;
  assign bus.scan_idx   = 3'(scan_q);
endmodule

// File: tb/tb_uart_display_buffer.sv
// Directed self-checking bench for uart_display_buffer (NUM_DIGITS=4, SCAN_DIV=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Each feature task compares observed outputs against hand-computed constants.
module tb_uart_display_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  uart_display_buffer_if #(.NUM_DIGITS(4)) dbus ();

  uart_display_buffer #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dbus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    dbus.rx_valid = 1'b0;
    dbus.rx_data  = 8'h00;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Present one byte for exactly one clock edge.
  task automatic send(input logic [7:0] d);
    dbus.rx_data  = d;
    dbus.rx_valid = 1'b1;
    step();
    dbus.rx_valid = 1'b0;
  endtask

  // Wait (bounded) until the scan reaches digit k.
  task automatic wait_scan(input logic [2:0] k, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (dbus.scan_idx == k) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  // Walk digits 0..3 comparing the character and enable seen at each.
  task automatic check_digits(input string name, input logic [7:0] ea [4], input logic [3:0] es [4]);
    bit ok;
    for (int k = 0; k < 4; k++) begin
      wait_scan(3'(k), ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s scan_timeout digit %0d: scan_idx=%0d", name, k, dbus.scan_idx);
      end else if (dbus.ascii_out !== ea[k] || dbus.digit_sel !== es[k]) begin
        n_fail++;
        $display("FAIL %s digit %0d: ascii=%h sel=%b, expected ascii=%h sel=%b",
                 name, k, dbus.ascii_out, dbus.digit_sel, ea[k], es[k]);
      end
    end
  endtask

  task automatic test_reset();
    dbus.rx_valid = 1'b0;
    dbus.rx_data  = 8'h00;
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if (dbus.ascii_out !== 8'h20 || dbus.digit_sel !== 4'b1111 ||
        dbus.char_count !== 4'd0 || dbus.scan_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: ascii=%h sel=%b cnt=%0d scan=%0d, expected 20 1111 0 0",
               dbus.ascii_out, dbus.digit_sel, dbus.char_count, dbus.scan_idx);
    end
    reset = 1'b0;
    // First tick lands on the 4th edge after release; then every 4 edges.
    for (int c = 1; c <= 16; c++) begin
      logic [2:0] es;
      step();
      es = 3'((c / 4) % 4);
      n_checks++;
      if (dbus.scan_idx !== es || dbus.digit_sel !== 4'b1111 || dbus.ascii_out !== 8'h20) begin
        n_fail++;
        $display("FAIL idle_scan cycle %0d: scan=%0d sel=%b ascii=%h, expected scan=%0d sel=1111 ascii=20",
                 c, dbus.scan_idx, dbus.digit_sel, dbus.ascii_out, es);
      end
    end
  endtask

  task automatic test_write();
    logic [7:0] ea [4] = '{8'h33, 8'h32, 8'h31, 8'h20};
    logic [3:0] es [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
    do_reset();
    // Before the edge the count is unchanged; right after it the write is visible.
    dbus.rx_data  = 8'h31;
    dbus.rx_valid = 1'b1;
    #1;
    n_checks++;
    if (dbus.char_count !== 4'd0) begin
      n_fail++;
      $display("FAIL latency_before_edge: cnt=%0d, expected 0", dbus.char_count);
    end
    step();
    n_checks++;
    if (dbus.char_count !== 4'd1) begin
      n_fail++;
      $display("FAIL latency_after_edge: cnt=%0d, expected 1", dbus.char_count);
    end
    send(8'h32);
    send(8'h33);
    n_checks++;
    if (dbus.char_count !== 4'd3) begin
      n_fail++;
      $display("FAIL write_count: cnt=%0d, expected 3", dbus.char_count);
    end
    check_digits("write_123", ea, es);
  endtask

  task automatic test_overflow();
    logic [7:0] ea [4] = '{8'h35, 8'h34, 8'h33, 8'h32};
    logic [3:0] es [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    do_reset();
    for (int i = 0; i < 5; i++) send(8'h31 + 8'(i));
    n_checks++;
    if (dbus.char_count !== 4'd4) begin
      n_fail++;
      $display("FAIL overflow_count: cnt=%0d, expected 4", dbus.char_count);
    end
    check_digits("overflow_12345", ea, es);
  endtask

  task automatic test_backspace();
    logic [7:0] ea [4] = '{8'h41, 8'h20, 8'h20, 8'h20};
    logic [3:0] es [4] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    logic [3:0] ec [3] = '{4'd1, 4'd0, 4'd0};
    do_reset();
    send(8'h41);
    send(8'h42);
    n_checks++;
    if (dbus.char_count !== 4'd2) begin
      n_fail++;
      $display("FAIL bs_fill_count: cnt=%0d, expected 2", dbus.char_count);
    end
    for (int i = 0; i < 3; i++) begin
      send(8'h08);
      n_checks++;
      if (dbus.char_count !== ec[i]) begin
        n_fail++;
        $display("FAIL bs_count step %0d: cnt=%0d, expected %0d", i, dbus.char_count, ec[i]);
      end
      if (i == 0) check_digits("bs_after_one", ea, es);
    end
  endtask

  task automatic test_esc_tick();
    logic [7:0] ea [4] = '{8'h50, 8'h4C, 8'h45, 8'h48};
    logic [3:0] es [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [2:0] prev;
    logic [2:0] s;
    bit ok;
    do_reset();
    send(8'h48);
    send(8'h45);
    send(8'h4C);
    send(8'h50);
    check_digits("help_fill", ea, es);
    // Find a scan advance, then the next tick cycle is 3 edges later.
    prev = dbus.scan_idx;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      step();
      if (dbus.scan_idx != prev) ok = 1'b1;
      prev = dbus.scan_idx;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL esc_tick_align: scan_idx never advanced, stuck at %0d", dbus.scan_idx);
    end
    step();
    step();
    step();
    s = dbus.scan_idx;
    send(8'h1B);
    n_checks++;
    if (dbus.char_count !== 4'd0 || dbus.digit_sel !== 4'b1111 ||
        dbus.scan_idx !== 3'((s + 3'd1) % 3'd4) || dbus.ascii_out !== 8'h20) begin
      n_fail++;
      $display("FAIL esc_with_tick: cnt=%0d sel=%b scan=%0d ascii=%h, expected 0 1111 %0d 20",
               dbus.char_count, dbus.digit_sel, dbus.scan_idx, dbus.ascii_out, (s + 1) % 4);
    end
  endtask

  task automatic test_ignored();
    logic [7:0] ea [4] = '{8'h59, 8'h58, 8'h20, 8'h20};
    logic [3:0] es [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    logic [7:0] junk [5] = '{8'h0D, 8'h80, 8'h7F, 8'h00, 8'hFF};
    do_reset();
    send(8'h58);
    send(8'h59);
    foreach (junk[i]) send(junk[i]);
    n_checks++;
    if (dbus.char_count !== 4'd2) begin
      n_fail++;
      $display("FAIL ignored_count: cnt=%0d, expected 2", dbus.char_count);
    end
    check_digits("ignored_bytes", ea, es);
  endtask

  task automatic test_mid_reset();
    do_reset();
    send(8'h31);
    send(8'h32);
    step();
    // Assert reset between edges together with a byte; clearing must not wait for a clock.
    dbus.rx_data  = 8'h5A;
    dbus.rx_valid = 1'b1;
    reset = 1'b1;
    #2;
    n_checks++;
    if (dbus.char_count !== 4'd0 || dbus.digit_sel !== 4'b1111 ||
        dbus.ascii_out !== 8'h20 || dbus.scan_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset: cnt=%0d sel=%b ascii=%h scan=%0d, expected 0 1111 20 0",
               dbus.char_count, dbus.digit_sel, dbus.ascii_out, dbus.scan_idx);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (dbus.char_count !== 4'd0 || dbus.ascii_out !== 8'h20) begin
      n_fail++;
      $display("FAIL reset_discards_rx: cnt=%0d ascii=%h, expected 0 20", dbus.char_count, dbus.ascii_out);
    end
    dbus.rx_valid = 1'b0;
    reset = 1'b0;
    step();
  endtask

  initial begin
    dbus.rx_valid = 1'b0;
    dbus.rx_data  = 8'h00;
    test_reset();
    test_write();
    test_overflow();
    test_backspace();
    test_esc_tick();
    test_ignored();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_display_buffer.md
UART_DISPLAY_BUFFER -- requirements
Module: uart_display_buffer

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of 7-segment digits buffered and scanned (legal range 2..8).
REQ-002 Parameter SCAN_DIV, default 50000, clock cycles per digit scan slot (legal minimum 2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_data  input  8  received byte from the UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data is valid in the same cycle.
REQ-007 ascii_out  output  8  ASCII code of the currently scanned digit; feeds the ASCII-to-7-segment decoder.
REQ-008 digit_sel  output  NUM_DIGITS  active-low digit enables, one-hot-low; bit i selects digit i, where digit 0 is the rightmost.
REQ-009 char_count  output  4  number of occupied digit positions, 0..NUM_DIGITS.
REQ-010 scan_idx  output  3  index of the currently scanned digit.

Function
REQ-011 The buffer shall hold NUM_DIGITS 8-bit character registers buf[0..NUM_DIGITS-1], where buf[0] is the newest character.
REQ-012 On rx_valid with a printable byte (0x20..0x7E): buf[i] <= buf[i-1] for i >= 1, buf[0] <= rx_data, and char_count increments, saturating at NUM_DIGITS.
REQ-013 When the buffer is full, the oldest character (buf[NUM_DIGITS-1]) shall be discarded silently; there is no stall and no error flag.
REQ-014 On rx_valid with 0x08 (backspace) and char_count > 0: buf[i] <= buf[i+1], buf[NUM_DIGITS-1] <= 0x20, and char_count decrements.
REQ-015 On rx_valid with 0x08 and char_count = 0, the block shall make no state change.
REQ-016 On rx_valid with 0x1B (ESC): all buf entries <= 0x20 and char_count <= 0, in one cycle.
REQ-017 All other bytes (0x00..0x1F other than 0x08/0x1B, and 0x7F..0xFF) shall be ignored with no state change.
REQ-018 A write shall be visible on ascii_out/digit_sel from the first clock edge after the rx_valid cycle; latency is 1 cycle.
REQ-019 The prescaler shall count 0..SCAN_DIV-1 and wrap, producing an internal tick in the cycle it equals SCAN_DIV-1.
REQ-020 On each tick, scan_idx shall advance by 1, wrapping from NUM_DIGITS-1 to 0.
REQ-021 ascii_out shall equal buf[scan_idx] combinationally from registers.
REQ-022 digit_sel[scan_idx] shall be 0 only if scan_idx < char_count; all other bits shall be 1, so empty positions stay dark.
REQ-023 If a tick and rx_valid occur in the same cycle, both take effect on that edge; the new scan_idx reads the updated buffer.
REQ-024 rx_valid held high for multiple cycles shall be treated as one byte per cycle; there is no edge detection.
REQ-025 The prescaler and scan shall run continuously, independent of rx activity.

Reset
REQ-026 While reset is high: buf all 0x20, char_count 0, scan_idx 0, prescaler 0.
REQ-027 Outputs during reset: ascii_out 0x20, digit_sel all ones.
REQ-028 Reset asserted mid-operation shall clear state immediately without waiting for a clock edge, discarding any rx_valid in that cycle.
REQ-029 After reset deasserts, the first tick shall occur SCAN_DIV cycles later.

Verification
REQ-030 Reset then idle 4*SCAN_DIV cycles (SCAN_DIV=4) -> digit_sel stays 4'b1111, scan_idx cycles 0,1,2,3,0, ascii_out 0x20 throughout.
REQ-031 Send "1","2","3" -> char_count 3; buf[0..2] = 0x33,0x32,0x31; digit_sel[3] never 0; digit_sel = 4'b1110 when scan_idx=0 with ascii_out 0x33.
REQ-032 Send "12345" with NUM_DIGITS=4 -> char_count 4; buf = 0x35,0x34,0x33,0x32; 0x31 dropped.
REQ-033 Send "AB", 0x08, 0x08, 0x08 -> char_count 2, then 1 (buf[0]=0x41), then 0, then unchanged at 0.
REQ-034 Fill with "HELP", then ESC in the same cycle as a scan tick -> next cycle char_count 0, digit_sel all ones, scan_idx advanced.
REQ-035 Send 0x0D, 0x80, and 0x7F -> no change to buf, char_count, or outputs.
